codeconv_sequencer: RTL and testbench

CODECONV_SEQUENCER -- requirements
Module: codeconv_sequencer

---
 rtl/codeconv_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_codeconv_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codeconv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : codeconv_sequencer
// Description : Sequences byte-conversion requests through an external
//               bin2gray / gray2bin converter. Requests are buffered in a
//               small FIFO, issued one at a time with a start pulse, and the
//               converter result is presented on a valid/ready output port.
//               Optional WAIT_DONE watchdog: define CODECONV_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH          input FIFO entries (power of two, >= 2)
//   TIMEOUT        WAIT_DONE watchdog limit in cycles (watchdog builds only)
// Ports
//   clk            single clock, rising edge
//   reset          synchronous active-high reset
//   in_valid       upstream item offered
//   in_ready       an item can be accepted (registered FIFO count < DEPTH)
//   in_mode        0 = bin2gray, 1 = gray2bin
//   in_data        byte to convert
//   conv_start     one-cycle start pulse to the converter
//   conv_mode      converter mode input
//   conv_data_in   converter data input
//   conv_data_out  converter result
//   conv_done      converter done flag
//   out_valid      result available
//   out_ready      downstream accepts result
//   out_data       converted byte
//   out_mode       mode used for out_data
//   fifo_count     items currently held in the input FIFO
//   timeout_err    sticky converter timeout flag (0 without the watchdog)
// ============================================================================
module codeconv_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [7:0]               in_data,
  output logic                     conv_start,
  output logic                     conv_mode,
  output logic [7:0]               conv_data_in,
  input  logic [7:0]               conv_data_out,
  input  logic                     conv_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_OUTPUT    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // --------------------------------------------------------------------------
  // Input FIFO: entry = {mode, data}
  // --------------------------------------------------------------------------
  logic [8:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_push;
  logic                w_pop;
  logic [8:0]          w_head;
  logic                w_timeout;

  // in_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot for a push into a full FIFO.
  assign in_ready   = (r_count < c_depth);
  assign fifo_count = r_count;
  assign w_push     = in_valid && in_ready;
  // A converter still asserting done from earlier activity blocks issue.
  assign w_pop      = (r_state == ST_IDLE) && (r_count != '0) && !conv_done;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_mode, in_data};
    end
  end

  // Pointers are exactly c_addr_w bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (conv_done) begin
          w_next_state = ST_OUTPUT;
        end else if (w_timeout) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // conv_start is the registered decode of the ISSUE state: the pulse lands
  // two edges after the pop, giving the converter a cycle of settled
  // conv_mode/conv_data_in before it is told to start.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_start   <= 1'b0;
      conv_mode    <= 1'b0;
      conv_data_in <= 8'h00;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      out_mode     <= 1'b0;
    end else begin
      conv_start <= (r_state == ST_ISSUE);
      // Loaded only on pop, so the request stays stable until back in IDLE.
      if (w_pop) begin
        conv_mode    <= w_head[8];
        conv_data_in <= w_head[7:0];
      end
      if ((r_state == ST_WAIT_DONE) && conv_done) begin
        out_data  <= conv_data_out;
        out_mode  <= conv_mode;
        out_valid <= 1'b1;
      end else if ((r_state == ST_OUTPUT) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // WAIT_DONE watchdog
  // --------------------------------------------------------------------------
`ifdef CODECONV_SEQ_TIMEOUT_EN
  localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_timeout_err;

  // Counter is zero on WAIT_DONE entry because it is held clear elsewhere;
  // the TIMEOUT-th waiting cycle without done abandons the item.
  assign w_timeout   = (r_state == ST_WAIT_DONE) && !conv_done &&
                       (r_to_cnt == c_to_last);
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ST_WAIT_DONE) begin
        r_to_cnt <= '0;
      end else if (!conv_done) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog WAIT_DONE waits for done indefinitely.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT;
  assign w_timeout            = 1'b0;
  assign timeout_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_codeconv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_codeconv_sequencer
// Description : Self-checking bench for codeconv_sequencer with a behavioural
//               converter model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codeconv_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_data;
  logic       conv_start;
  logic       conv_mode;
  logic [7:0] conv_data_in;
  logic [7:0] conv_data_out;
  logic       conv_done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_mode;
  logic [2:0] fifo_count;
  logic       timeout_err;

  codeconv_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (16)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_data       (in_data),
    .conv_start    (conv_start),
    .conv_mode     (conv_mode),
    .conv_data_in  (conv_data_in),
    .conv_data_out (conv_data_out),
    .conv_done     (conv_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mode      (out_mode),
    .fifo_count    (fifo_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int         n_total   = 0;
  int         n_bad     = 0;
  int         out_fires = 0;
  int         starts    = 0;
  logic       prev_start = 1'b0;
  logic       hold_pend  = 1'b0;
  logic [8:0] hold_val   = '0;
  logic [8:0] last_out   = '0;
  logic [8:0] exp_item;
  logic [8:0] exp_q [$];

  logic       conv_hold = 1'b0;
  logic       conv_mute = 1'b0;
  int         cm_cnt    = 0;
  logic [7:0] cm_res    = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] conv_f(input logic m, input logic [7:0] d);
    logic [7:0] r;
    if (!m) begin
      r = d ^ (d >> 1);
    end else begin
      r[7] = d[7];
      for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ d[i];
    end
    return r;
  endfunction

  // Converter model: done pulses 3 cycles after the start pulse is seen.
  always @(negedge clk) begin
    if (conv_hold) begin
      conv_done = 1'b1;
    end else if (conv_start && !conv_mute) begin
      cm_cnt    = 3;
      cm_res    = conv_f(conv_mode, conv_data_in);
      conv_done = 1'b0;
    end else if (cm_cnt > 0) begin
      cm_cnt = cm_cnt - 1;
      if (cm_cnt == 0) begin
        conv_done     = 1'b1;
        conv_data_out = cm_res;
      end else begin
        conv_done = 1'b0;
      end
    end else begin
      conv_done = 1'b0;
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) exp_q.push_back({in_mode, conv_f(in_mode, in_data)});
      if (out_valid) begin
        if (hold_pend) check("out_stable", {23'd0, out_mode, out_data}, {23'd0, hold_val});
        if (out_ready) begin
          out_fires++;
          last_out = {out_mode, out_data};
          if (exp_q.size() == 0) begin
            check("out_extra", 32'd1, 32'd0);
          end else begin
            exp_item = exp_q.pop_front();
            check("out_item", {23'd0, out_mode, out_data}, {23'd0, exp_item});
          end
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_val  = {out_mode, out_data};
        end
      end else begin
        hold_pend = 1'b0;
      end
      if (conv_start) begin
        check("start_pulse", {31'd0, prev_start}, 32'd0);
        starts++;
      end
      prev_start = conv_start;
    end else begin
      hold_pend  = 1'b0;
      prev_start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic m, input logic [7:0] d);
    int   guard;
    logic acc;
    guard    = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 60);
    if (!acc) check("push_stall", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 300) begin
      tick();
      g++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic wait_cond_valid(input string tag);
    int g;
    g = 0;
    while (!out_valid && g < 100) begin
      tick();
      g++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0;
    int f0;
    int n;
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_mode       = 1'b0;
    in_data       = 8'h00;
    out_ready     = 1'b1;
    conv_done     = 1'b0;
    conv_data_out = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_start", {31'd0, conv_start}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_odata", {24'd0, out_data}, 32'd0);
    check("rst_cdata", {24'd0, conv_data_in}, 32'd0);

    // Single item, issue latency and result
    push_item(1'b0, 8'h55);
    check("t1_cnt_n", {29'd0, fifo_count}, 32'd1);
    tick();
    check("t1_cnt_n1", {29'd0, fifo_count}, 32'd0);
    check("t1_cdata", {24'd0, conv_data_in}, 32'h55);
    check("t1_start_n1", {31'd0, conv_start}, 32'd0);
    tick();
    check("t1_start_n2", {31'd0, conv_start}, 32'd1);
    tick();
    check("t1_start_n3", {31'd0, conv_start}, 32'd0);
    f0 = out_fires;
    wait_drain();
    check("t1_pulses", out_fires - f0, 32'd1);
    check("t1_result", {23'd0, last_out}, 32'h07F);

    // Backpressure, fill to full, ordering
    out_ready = 1'b0;
    push_item(1'b0, 8'h01);
    push_item(1'b0, 8'h0F);
    push_item(1'b0, 8'hA3);
    push_item(1'b0, 8'hFF);
    check("t2_cnt3", {29'd0, fifo_count}, 32'd3);
    check("t2_rdy3", {31'd0, in_ready}, 32'd1);
    push_item(1'b0, 8'h00);
    check("t2_cnt4", {29'd0, fifo_count}, 32'd4);
    check("t2_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 8'h77;
    repeat (3) begin
      tick();
      check("t2_full_hold", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("t2_cnt_hold", {29'd0, fifo_count}, 32'd4);
    wait_cond_valid("t2_valid");
    repeat (4) tick();
    check("t2_hold_data", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    wait_drain();
    check("t2_last", {23'd0, last_out}, 32'h000);

    // Converter done stuck high blocks issue
    conv_hold = 1'b1;
    tick();
    s0 = starts;
    push_item(1'b1, 8'h08);
    repeat (6) tick();
    check("t3_nostart", starts - s0, 32'd0);
    check("t3_cnt", {29'd0, fifo_count}, 32'd1);
    conv_hold = 1'b0;
    wait_drain();
    check("t3_result", {23'd0, last_out}, 32'h10F);

    // Simultaneous push and pop at count 1
    push_item(1'b0, 8'h3C);
    push_item(1'b1, 8'hC3);
    check("t4_cnt_pp1", {29'd0, fifo_count}, 32'd1);
    wait_cond_valid("t4_valid");
    tick();
    push_item(1'b0, 8'h5A);
    check("t4_cnt_pp2", {29'd0, fifo_count}, 32'd1);
    check("t4_cdata", {24'd0, conv_data_in}, 32'hC3);
    wait_drain();
    for (int k = 0; k < 10; k++) begin
      push_item(1'($urandom_range(0, 1)), 8'($urandom));
    end
    wait_drain();

    // Reset while waiting for the converter
    conv_mute = 1'b1;
    s0 = starts;
    push_item(1'b0, 8'h33);
    push_item(1'b0, 8'h44);
    n = 0;
    while (starts == s0 && n < 50) begin
      tick();
      n++;
    end
    check("t5_started", {31'd0, (starts != s0)}, 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_start", {31'd0, conv_start}, 32'd0);
    check("t5_cnt", {29'd0, fifo_count}, 32'd0);
    check("t5_ready", {31'd0, in_ready}, 32'd1);
    check("t5_cdata", {24'd0, conv_data_in}, 32'd0);
    conv_mute = 1'b0;
    conv_hold = 1'b1;
    s0 = starts;
    f0 = out_fires;
    repeat (2) tick();
    conv_hold = 1'b0;
    repeat (6) tick();
    check("t5_no_out", out_fires - f0, 32'd0);
    check("t5_no_start", starts - s0, 32'd0);

`ifdef CODECONV_SEQ_TIMEOUT_EN
    // Watchdog drops a stuck item and moves to the next
    conv_mute = 1'b1;
    push_item(1'b0, 8'hAA);
    push_item(1'b1, 8'h55);
    n = 0;
    while (!conv_start && n < 50) begin
      tick();
      n++;
    end
    check("t6_first_start", {31'd0, conv_start}, 32'd1);
    conv_mute = 1'b0;
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("t6_cycles", n, 32'd16);
    check("t6_terr", {31'd0, timeout_err}, 32'd1);
    check("t6_novalid", {31'd0, out_valid}, 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    wait_drain();
    check("t6_result", {23'd0, last_out}, 32'h166);
    check("t6_sticky", {31'd0, timeout_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_terr", {31'd0, timeout_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
